// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and helpers for the shift sequencer: FSM state encoding,
// shift-direction constants and the parity helper used on the serial link.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Even parity (XOR of all bits); narrower words are zero-extended by the caller.
    function automatic logic even_parity(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/response and serial-link signal bundle of the shift sequencer.
// master = client/link side, slave = shift_seq_ctrl.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;
    logic             sd_in;
    logic             sd_out;
    logic             sd_en;
    logic             busy;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_perr;

    modport master (
        output cmd_valid, cmd_dir, cmd_data, sd_in, rsp_ready,
        input  cmd_ready, sd_out, sd_en, busy, rsp_valid, rsp_data, rsp_perr
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_data, sd_in, rsp_ready,
        output cmd_ready, sd_out, sd_en, busy, rsp_valid, rsp_data, rsp_perr
    );
endinterface

// File: rtl/shift_seq_ctrl_core.sv
// bidir_shift_core: WIDTH-bit shift register with parallel load and
// single-bit left/right shift. out_bit is the bit that sits at the serial
// output end once the pending load/shift of this cycle has taken effect, so
// the controller can register it in lock-step with the register itself.
module bidir_shift_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             out_bit
);

    logic [WIDTH-1:0] d_s;

    // Next register value: load has priority over shift, otherwise hold.
    always_comb begin
        d_s = q;
        if (load) begin
            d_s = load_data;
        end else if (shift_en) begin
            if (dir == DIR_RIGHT) begin
                d_s = {ser_in, q[WIDTH-1:1]};
            end else begin
                d_s = {q[WIDTH-2:0], ser_in};
            end
        end else begin
            d_s = q;
        end
        out_bit = (dir == DIR_RIGHT) ? d_s[0] : d_s[WIDTH-1];
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d_s;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: runs one full-duplex serial word exchange per command
// (parallel load, WIDTH shifts, parallel response over valid/ready).
// Optional build macro SHIFT_PARITY_EN adds a trailing parity bit cycle and
// the rsp_perr check; without it rsp_perr is tied low.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    shift_seq_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             dir_r, dir_s;
    logic             load_s, shift_s;
    logic             sd_out_r, sd_out_s;
    logic             sd_en_r, sd_en_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic             cmd_ready_r, busy_r;
    logic [WIDTH-1:0] q_s;
    logic             out_bit_s;
`ifdef SHIFT_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);
    logic             par_tx_r, par_tx_s;
    logic             perr_r, perr_s;
`endif

    bidir_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (bus.cmd_data),
        .shift_en  (shift_s),
        .dir       (dir_s),
        .ser_in    (bus.sd_in),
        .q         (q_s),
        .out_bit   (out_bit_s)
    );

    // Next-state and next-output decode of the exchange sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dir_s       = dir_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        sd_out_s    = 1'b0;
        sd_en_s     = 1'b0;
        rsp_valid_s = 1'b0;
`ifdef SHIFT_PARITY_EN
        par_tx_s    = par_tx_r;
        perr_s      = perr_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    load_s   = 1'b1;
                    dir_s    = bus.cmd_dir;
                    cnt_s    = '0;
                    state_s  = SHIFT;
                    sd_en_s  = 1'b1;
                    sd_out_s = out_bit_s;
`ifdef SHIFT_PARITY_EN
                    par_tx_s = even_parity(64'(bus.cmd_data));
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    // Last data bit is shifted in on this edge.
                    shift_s = 1'b1;
                    cnt_s   = cnt_r + CNT_ONE;
`ifdef SHIFT_PARITY_EN
                    sd_en_s  = 1'b1;
                    sd_out_s = par_tx_r;
`else
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
`endif
                end
`ifdef SHIFT_PARITY_EN
                else if (cnt_r == PAR_CNT) begin
                    // Parity cycle: sample the received parity, register holds.
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    perr_s      = bus.sd_in ^ even_parity(64'(q_s));
                end
`endif
                else begin
                    shift_s  = 1'b1;
                    cnt_s    = cnt_r + CNT_ONE;
                    sd_en_s  = 1'b1;
                    sd_out_s = out_bit_s;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer state, counter, latched direction and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            dir_r       <= DIR_LEFT;
            sd_out_r    <= 1'b0;
            sd_en_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            dir_r       <= dir_s;
            sd_out_r    <= sd_out_s;
            sd_en_r     <= sd_en_s;
            rsp_valid_r <= rsp_valid_s;
            cmd_ready_r <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
        end
    end

`ifdef SHIFT_PARITY_EN
    // Transmit parity latched at acceptance and received-parity error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_tx_r <= 1'b0;
            perr_r   <= 1'b0;
        end else begin
            par_tx_r <= par_tx_s;
            perr_r   <= perr_s;
        end
    end

    assign bus.rsp_perr = perr_r;
`else
    assign bus.rsp_perr = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.sd_out    = sd_out_r;
    assign bus.sd_en     = sd_en_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = q_s;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer that owns a WIDTH-bit bidirectional shift register and runs one full-duplex serial word exchange per command.
- Each command does three things: parallel load, WIDTH single-bit shifts in the commanded direction, then a parallel result returned over a valid/ready response.
- Sits between a parallel command/response client and a serial bit link (SPI-like), replacing free-running shift-register control.

Parameters:
- WIDTH, 8, shift register and data word width in bits; minimum 2.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_dir  in  1  1 = right (LSB out first, sd_in enters MSB); 0 = left (MSB out first, sd_in enters LSB)
- cmd_data  in  WIDTH  word to transmit
- sd_in  in  1  serial input bit, sampled on each clk edge while sd_en = 1
- sd_out  out  1  serial output bit, registered
- sd_en  out  1  bit strobe, high for each shift cycle
- busy  out  1  exchange in progress (state != IDLE)
- rsp_valid  out  1  received word available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  received word
- rsp_perr  out  1  parity error flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, async) forces: state IDLE, shift register 0, counter 0, sd_out 0, sd_en 0, rsp_valid 0, rsp_data 0, rsp_perr 0, busy 0, cmd_ready 1.
- Reset asserted mid-exchange aborts the exchange; no response is produced.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready at edge N: latch cmd_dir, load register with cmd_data, clear counter, go SHIFT.
  - SHIFT: sd_en = 1 for exactly WIDTH cycles (N+1 .. N+WIDTH).
    - sd_out shows reg[0] (right) or reg[WIDTH-1] (left).
    - Each edge: right shift reg <= {sd_in, reg[WIDTH-1:1]}; left shift reg <= {reg[WIDTH-2:0], sd_in}. Counter increments.
    - When the counter reaches WIDTH-1 at the edge, go RESP.
  - RESP: rsp_valid = 1 from cycle N+WIDTH+1; rsp_data = final register contents (the received word).
    - rsp_data and rsp_valid stay stable until rsp_valid && rsp_ready, then go IDLE.
    - rsp_valid drops the next cycle; rsp_data holds its last value.
- cmd_ready is low in SHIFT and RESP. cmd_valid outside IDLE is ignored and not queued.
- Minimum command-to-command spacing is WIDTH+2 cycles, because IDLE always lasts at least one cycle.
- cmd_dir and cmd_data are sampled only at acceptance; later changes have no effect.
- sd_out and sd_en are registered outputs with no combinational path from inputs.
- In IDLE and RESP: sd_out = 0, sd_en = 0.

Optional Feature:
- Macro SHIFT_PARITY_EN.
- Defined:
  - SHIFT becomes WIDTH+1 cycles. The extra final cycle drives sd_out = even parity (XOR) of the latched cmd_data and samples sd_in as the received parity bit without shifting the register.
  - rsp_perr = 1 in RESP when the received parity bit != XOR of rsp_data; it is valid with rsp_valid.
  - Spacing becomes WIDTH+3 cycles.
- Undefined: rsp_perr is tied 0, and timing is as above.

Decomposition:
- Package shift_seq_pkg:
  - state typedef (IDLE, SHIFT, RESP)
  - constants DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
- Sub-module bidir_shift_core: WIDTH-bit register with load, shift_en, dir and serial in; outputs the register and the current out-bit.
- shift_seq_ctrl holds the FSM, counter, handshakes and parity.

Test Plan (WIDTH=8):
- Right exchange: cmd_data=0x1E, dir=1, sd_in driven LSB-first with 0x3C -> sd_out sequence 0,1,1,1,1,0,0,0 on 8 sd_en cycles; rsp_valid at cycle N+9; rsp_data=0x3C.
- Left exchange: cmd_data=0x1E, dir=0, sd_in driven MSB-first with 0x5A -> sd_out sequence 0,0,0,1,1,1,1,0; rsp_data=0x5A.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_valid/rsp_data stable; cmd_ready=0; cmd_valid pulses ignored; after acceptance, IDLE one cycle, then the next command is accepted.
- Mid-exchange reset: rst_n low after 3 sd_en cycles -> all outputs immediately at reset values; after release cmd_ready=1, no rsp_valid; a fresh exchange of 0xA5 completes correctly.
- Command change during SHIFT: cmd_data/cmd_dir toggled every cycle after acceptance -> serial output still matches the latched word and direction.
- SHIFT_PARITY_EN: cmd_data=0x1E -> 9th sd_out bit 0; receive 0x3C with parity bit 1 -> rsp_perr=1; with parity bit 0 -> rsp_perr=0.
